// File: rtl/serial_mem_responder.sv
// serial_mem_responder: bit-serial load/store slave with an internal word-organised SRAM
module serial_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_req,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_rmask,
   input  logic [3:0]  mem_wmask,
   output logic        mem_rbit,
   output logic        mem_rbit_valid,
   input  logic        mem_wbit,
   output logic        mem_wbit_ready,
   output logic        mem_resp,
   output logic        mem_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RBITS, S_WBITS, S_RESP} state_t;

   state_t        r_state, w_next, w_dispatch;
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_idx, w_idx;
   logic [3:0]    r_rmask, r_wmask, w_rm, w_wm;
   logic          r_err, w_err_in, w_err, w_accept;
   logic [LW-1:0] r_lat;
   logic [4:0]    r_bit;
   logic [31:0]   r_shift, w_wword, w_rexp;

   assign w_accept = mem_req && (r_state == S_IDLE);
   assign w_err_in = (mem_addr[1:0] != 2'b00) || ((mem_addr >> (AW + 2)) != 32'd0);
   // With LATENCY=0 the dispatch happens on the accept edge, so it must see the live inputs
   assign w_idx    = (r_state == S_IDLE) ? mem_addr[AW+1:2] : r_idx;
   assign w_rm     = (r_state == S_IDLE) ? mem_rmask : r_rmask;
   assign w_wm     = (r_state == S_IDLE) ? mem_wmask : r_wmask;
   assign w_err    = (r_state == S_IDLE) ? w_err_in : r_err;
   assign w_rexp   = {{8{w_rm[3]}}, {8{w_rm[2]}}, {8{w_rm[1]}}, {8{w_rm[0]}}};
   assign w_wword  = {mem_wbit, r_shift[31:1]};

   assign mem_ready      = (r_state == S_IDLE);
   assign mem_rbit_valid = (r_state == S_RBITS);
   assign mem_rbit       = (r_state == S_RBITS) && r_shift[0];
   assign mem_wbit_ready = (r_state == S_WBITS);
   assign mem_resp       = (r_state == S_RESP);
   assign mem_err        = (r_state == S_RESP) && r_err;

   // Next-state logic including the same-cycle dispatch decision
   always_comb begin
      w_dispatch = (w_wm != 4'd0 && !w_err) ? S_WBITS :
                   (w_rm != 4'd0 && !w_err) ? S_RBITS : S_RESP;
      w_next = r_state;
      case (r_state)
         S_IDLE:           if (mem_req) w_next = (LATENCY == 0) ? w_dispatch : S_WAIT;
         S_WAIT:           if (r_lat == LW'(LATENCY - 1)) w_next = w_dispatch;
         S_RBITS, S_WBITS: if (r_bit == 5'd31) w_next = S_RESP;
         S_RESP:           w_next = S_IDLE;
         default:          w_next = S_IDLE;
      endcase
   end

   // State, request latches, counters and the shared read/write shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_rmask <= 4'd0;
         r_wmask <= 4'd0;
         r_err   <= 1'b0;
         r_lat   <= '0;
         r_bit   <= 5'd0;
         r_shift <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_idx   <= mem_addr[AW+1:2];
            r_rmask <= mem_rmask;
            r_wmask <= mem_wmask;
            r_err   <= w_err_in;
         end
         r_lat <= (r_state == S_WAIT && w_next == S_WAIT) ? r_lat + 1'b1 : '0;
         r_bit <= (r_state == S_RBITS || r_state == S_WBITS) ? r_bit + 5'd1 : 5'd0;
         if (w_next == S_RBITS && r_state != S_RBITS)
            r_shift <= r_mem[w_idx] & w_rexp;
         else if (r_state == S_RBITS)
            r_shift <= r_shift >> 1;
         else if (r_state == S_WBITS)
            r_shift <= w_wword;
      end
   end

   // Array commit on the edge that samples bit 31; contents survive reset
   always_ff @(posedge clk) begin
      if (r_state == S_WBITS && r_bit == 5'd31)
         for (int i = 0; i < 4; i++)
            if (r_wmask[i]) r_mem[r_idx][8*i +: 8] <= w_wword[8*i +: 8];
   end
endmodule

// File: tb/tb_serial_mem_responder.sv
// tb_serial_mem_responder: directed plus randomized checks against a word-array reference model
module tb_serial_mem_responder;
   localparam int DEPTH = 16;
   localparam int LAT   = 2;

   logic        clk = 1'b0, rst_n = 1'b0, mem_req = 1'b0, mem_wbit = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [3:0]  mem_rmask = 4'd0, mem_wmask = 4'd0;
   logic        mem_ready, mem_rbit, mem_rbit_valid, mem_wbit_ready, mem_resp, mem_err;
   int          vec = 0, errs = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] got;

   serial_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
      .mem_rbit(mem_rbit), .mem_rbit_valid(mem_rbit_valid), .mem_wbit(mem_wbit),
      .mem_wbit_ready(mem_wbit_ready), .mem_resp(mem_resp), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bexp(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   function automatic logic [31:0] outs();
      return {26'd0, mem_ready, mem_rbit_valid, mem_rbit, mem_wbit_ready, mem_resp, mem_err};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction, checking every output on every cycle until ready returns
   task automatic txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] wd, input bit hold, output logic [31:0] rd_word);
      bit          err, rd, wr, inw;
      int          nb, rc, k, idx;
      logic [31:0] snap;
      logic [5:0]  ex;
      err  = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
      wr   = !err && wm != 4'd0;
      rd   = !err && wm == 4'd0 && rm != 4'd0;
      nb   = (rd || wr) ? 32 : 0;
      rc   = LAT + 1 + nb;
      idx  = int'(a / 4) % DEPTH;
      snap = rd ? (model[idx] & bexp(rm)) : 32'd0;
      rd_word = 32'd0;
      @(negedge clk);
      chk("ready_before_req", {31'd0, mem_ready}, 32'd1);
      mem_req = 1'b1; mem_addr = a; mem_rmask = rm; mem_wmask = wm;
      for (int c = 1; c <= rc + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            mem_addr  = $urandom;
            mem_rmask = 4'($urandom);
            mem_wmask = 4'($urandom);
            if (!hold) mem_req = 1'b0;
         end
         k   = c - LAT - 1;
         inw = (nb != 0) && k >= 0 && k < 32;
         ex  = {c == rc + 1, rd && inw, (rd && inw) ? snap[k] : 1'b0, wr && inw, c == rc, c == rc && err};
         chk($sformatf("outs a=%h rm=%h wm=%h c=%0d", a, rm, wm, c), outs(), {26'd0, ex});
         if (mem_rbit_valid && inw) rd_word[k] = mem_rbit;
         mem_wbit = (wr && inw) ? wd[k] : 1'b0;
         if (c == rc) mem_req = 1'b0;
      end
      if (wr) model[idx] = (model[idx] & ~bexp(wm)) | (wd & bexp(wm));
      if (rd) chk($sformatf("read_word a=%h rm=%h", a, rm), rd_word, snap);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [3:0]  rm, wm;
      int          sel;
      repeat (2) @(negedge clk);
      chk("reset_outs", outs(), 32'h20);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) txn(32'(i * 4), 4'h0, 4'hF, $urandom, 1'b0, got);
      txn(32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, got);
      txn(32'h10, 4'hF, 4'h0, 32'h0, 1'b0, got);
      chk("rd_full_word", got, 32'hDEADBEEF);
      txn(32'h10, 4'h0, 4'h2, 32'h0000AA00, 1'b0, got);
      txn(32'h10, 4'h3, 4'h0, 32'h0, 1'b0, got);
      chk("rd_mask3", got, 32'h0000AAEF);
      txn(32'h10, 4'h8, 4'h0, 32'h0, 1'b0, got);
      chk("rd_mask8", got, 32'hDE000000);
      txn(32'h10, 4'h8, 4'h4, 32'h00550000, 1'b0, got);
      txn(32'h10, 4'hF, 4'h0, 32'h0, 1'b0, got);
      chk("write_wins", got, 32'hDE55AAEF);
      txn(32'h2, 4'hF, 4'h0, 32'h0, 1'b0, got);
      txn(32'(4 * DEPTH), 4'h0, 4'hF, 32'hFFFFFFFF, 1'b0, got);
      txn(32'h0, 4'hF, 4'h0, 32'h0, 1'b0, got);
      txn(32'h8, 4'h0, 4'h0, 32'h0, 1'b0, got);
      txn(32'h14, 4'hF, 4'h0, 32'h0, 1'b1, got);
      txn(32'h18, 4'h0, 4'hF, 32'hCAFEF00D, 1'b1, got);
      txn(32'h18, 4'hF, 4'h0, 32'h0, 1'b0, got);
      d = 32'h12345678;
      @(negedge clk);
      mem_req = 1'b1; mem_addr = 32'h20; mem_rmask = 4'h0; mem_wmask = 4'hF;
      for (int c = 1; c <= LAT + 10; c++) begin
         @(negedge clk);
         mem_req = 1'b0;
         mem_wbit = (c > LAT) ? d[c - LAT - 1] : 1'b0;
      end
      @(negedge clk);
      chk("mid_write_busy", {31'd0, mem_wbit_ready}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_write_reset_outs", outs(), 32'h20);
      @(negedge clk);
      rst_n = 1'b1;
      txn(32'h20, 4'hF, 4'h0, 32'h0, 1'b0, got);
      for (int n = 0; n < 40; n++) begin
         a   = 32'($urandom_range(0, DEPTH - 1) * 4);
         sel = $urandom_range(0, 7);
         if (sel == 0) a = a | 32'($urandom_range(1, 3));
         if (sel == 1) a = a + 32'(4 * DEPTH * $urandom_range(1, 100));
         rm = 4'($urandom);
         wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         txn(a, rm, wm, $urandom, $urandom_range(0, 1) == 1, got);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/serial_mem_responder.md
Name: serial_mem_responder

Overview:
- Data-memory responder for the bit-serial core: the slave end of the core's load/store interface.
- Accepts one request at a time (word address plus byte masks) through a valid/ready handshake.
- Waits a fixed access latency, then streams 32 read bits out LSB-first, or shifts 32 write bits in LSB-first and commits them.
- Pulses a one-cycle response at completion. Sits between the core's memory mux / store path and a word-organised SRAM array held inside the block.

Parameters:
- DEPTH, 256, number of 32-bit words in the internal array; must be a power of two, at least 2.
- LATENCY, 2, cycles spent in WAIT after request acceptance; 0 is legal and skips WAIT.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  in  1  request valid.
- mem_ready  out  1  responder can accept a request; high only in IDLE.
- mem_addr  in  32  byte address; word index is mem_addr[log2(DEPTH)+1:2].
- mem_rmask  in  4  byte read mask; bit i covers data bits 8i+7:8i.
- mem_wmask  in  4  byte write mask; a nonzero value makes the request a write.
- mem_rbit  out  1  serial read data, LSB-first.
- mem_rbit_valid  out  1  mem_rbit is valid this cycle.
- mem_wbit  in  1  serial write data, LSB-first.
- mem_wbit_ready  out  1  responder samples mem_wbit at this cycle's rising edge.
- mem_resp  out  1  one-cycle completion pulse.
- mem_err  out  1  qualifies mem_resp: out-of-range or misaligned request.

Behaviour:
- Reset (async assert, sync release): state=IDLE, bit counter=0, latency counter=0.
  - Outputs at reset: mem_ready=1, mem_rbit=0, mem_rbit_valid=0, mem_wbit_ready=0, mem_resp=0, mem_err=0.
  - The array is not reset; contents are retained across reset.
- Request acceptance: at an edge where mem_req & mem_ready, the block latches addr, rmask, wmask and computes err.
- err is set when any of the following holds:
  - addr[1:0] != 0;
  - any addr bit above log2(DEPTH)+1 is nonzero.
- State machine:
  - IDLE -> WAIT on accept when LATENCY>0; IDLE -> DISPATCH when LATENCY=0.
  - WAIT: counts LATENCY cycles, then goes to DISPATCH.
  - DISPATCH is a same-cycle decision, not a state. It selects:
    - WBITS if wmask!=0 and !err;
    - RBITS if wmask==0 and rmask!=0 and !err;
    - RESP otherwise (err, or both masks zero).
  - RBITS (32 cycles): a word snapshot is taken at entry, with unmasked bytes forced to 0.
    - mem_rbit_valid=1 and mem_rbit=snapshot[k] in the k-th RBITS cycle, k=0..31.
    - After k=31 -> RESP.
  - WBITS (32 cycles): mem_wbit_ready=1; mem_wbit is shifted in as bit k on the k-th edge.
    - At the edge sampling k=31, bytes selected by wmask are written into the array; unselected bytes are unchanged.
    - Then -> RESP.
  - RESP (1 cycle): mem_resp=1 and mem_err=err; next state IDLE.
- Priority and illegal cases:
  - wmask!=0 wins over rmask; rmask is ignored on writes.
  - Errored requests never write and never stream bits.
- Timing:
  - Read accepted at edge T: first bit is visible in cycle T+1+LATENCY, last bit in T+32+LATENCY, mem_resp in T+33+LATENCY.
  - Write follows the same timing, with mem_wbit_ready covering the same 32 cycles.
  - Back-to-back: mem_ready returns the cycle after RESP, so the minimum request spacing is 34+LATENCY cycles.
- mem_req while not ready is ignored; no queuing.
- Inputs are sampled only at acceptance; later changes to mem_addr or the masks have no effect.
- Reset mid-operation: the transaction is aborted and the state returns to IDLE.
  - A partial write is discarded, because the array write occurs only at bit 31.
  - A partial read produces no mem_resp.
- The bit counter is 5 bits and wraps 31->0 exactly at the state exit.

Test Plan:
- Write/read word: write addr 0x10, wmask 0xF, serial 0xDEADBEEF; read addr 0x10, rmask 0xF -> rbit stream 0xDEADBEEF LSB-first, resp at T+35 (LATENCY=2), err=0.
- Byte masking: after the above, write wmask 0x2 data 0x0000AA00; read rmask 0x3 -> 0x0000AAEF; read rmask 0x8 -> 0xDE000000.
- Error: read addr 0x2 -> no rbit_valid, resp+err=1 at T+3; write addr 4*DEPTH -> no array change, resp+err=1.
- Reset mid-write: assert rst_n=0 after 10 wbits of 0x12345678 to addr 0x20 -> outputs take reset values; reading 0x20 returns the prior contents.
- LATENCY=0 build: read accepted at T -> first valid bit at T+1, resp at T+33; mem_req held high during busy cycles -> exactly one transaction.
- Null request: rmask=wmask=0 -> resp=1, err=0 after LATENCY+1 cycles, no bit traffic.
